// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit: instruction fetch plus single-port data access sequencer.
// Ports: clk/reset, mem_* memory bus, next_req/br_* fetch control,
// ld_req/st_req/dat_addr/st_data data access, halt, ir/ir_valid,
// ld_data/dat_done, pc, err. Optional wait timeout: FMU_TIMEOUT_EN.
module fetch_mem_unit #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 16,
  parameter int RESET_PC    = 0,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              next_req,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] dat_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              halt,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              dat_done,
  output logic [ADDR_W-1:0] pc,
  output logic              err
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_DATA,
    S_HALT
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic                lat_wr;

`ifdef FMU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wcnt;
  logic          err_q;
  assign err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign err = 1'b0;
`endif

  always_comb begin
    mem_cmd   = CMD_NONE;
    mem_addr  = pc;
    mem_wdata = lat_data;
    unique case (state)
      S_FETCH: mem_cmd = CMD_READ;
      S_DATA: begin
        mem_cmd  = lat_wr ? CMD_WRITE : CMD_READ;
        mem_addr = lat_addr;
      end
      default: mem_cmd = CMD_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= ADDR_W'(RESET_PC);
      ir       <= '0;
      ir_valid <= 1'b0;
      ld_data  <= '0;
      dat_done <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
`ifdef FMU_TIMEOUT_EN
      wcnt     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      dat_done <= 1'b0;
`ifdef FMU_TIMEOUT_EN
      // Cleared unless a wait cycle below extends the run.
      wcnt     <= '0;
`endif
      unique case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir       <= mem_rdata;
            pc       <= pc + ADDR_W'(1);
            ir_valid <= 1'b1;
            state    <= S_EXEC;
          end else begin
`ifdef FMU_TIMEOUT_EN
            if (wcnt == CW'(TIMEOUT_CYC - 1)) begin
              err_q <= 1'b1;
              state <= S_HALT;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
`endif
          end
        end
        S_EXEC: begin
          if (halt) begin
            ir_valid <= 1'b0;
            state    <= S_HALT;
          end else if (ld_req || st_req) begin
            // Load wins a simultaneous load/store.
            lat_addr <= dat_addr;
            lat_data <= st_data;
            lat_wr   <= ~ld_req;
            state    <= S_DATA;
          end else if (next_req) begin
            pc       <= br_take ? br_target : pc;
            ir_valid <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_DATA: begin
          if (mem_ready) begin
            dat_done <= 1'b1;
            if (!lat_wr) ld_data <= mem_rdata;
            state    <= S_EXEC;
          end else begin
`ifdef FMU_TIMEOUT_EN
            if (wcnt == CW'(TIMEOUT_CYC - 1)) begin
              err_q    <= 1'b1;
              ir_valid <= 1'b0;
              state    <= S_HALT;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
`endif
          end
        end
        default: begin
          ir_valid <= 1'b0;
          state    <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_mem_unit.md
FETCH_MEM_UNIT -- requirements
Module: fetch_mem_unit

Interface
REQ-001 Parameter ADDR_W, default 9, memory address width in bits.
REQ-002 Parameter DATA_W, default 16, instruction and data word width in bits.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 Parameter TIMEOUT_CYC, default 15, wait-cycle limit; used only when FMU_TIMEOUT_EN is defined.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 mem_cmd  out  2  memory command: 00 NONE, 01 READ, 10 WRITE.
REQ-008 mem_addr  out  ADDR_W  memory address.
REQ-009 mem_wdata  out  DATA_W  store data.
REQ-010 mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1.
REQ-011 mem_ready  in  1  memory completes the current access this cycle.
REQ-012 next_req  in  1  core has finished the current instruction.
REQ-013 br_take  in  1  with next_req, redirect the PC.
REQ-014 br_target  in  ADDR_W  branch destination.
REQ-015 ld_req / st_req  in  1 each  data load / store request.
REQ-016 dat_addr  in  ADDR_W  data access address.
REQ-017 st_data  in  DATA_W  data to store.
REQ-018 halt  in  1  stop; remain halted until reset.
REQ-019 ir  out  DATA_W  current instruction.
REQ-020 ir_valid  out  1  ir holds a valid instruction.
REQ-021 ld_data  out  DATA_W  last loaded word.
REQ-022 dat_done  out  1  one-cycle pulse when a data access completes.
REQ-023 pc  out  ADDR_W  address of the next fetch.
REQ-024 err  out  1  sticky timeout flag.

Function
REQ-025 The block SHALL implement the states FETCH, EXEC, DATA and HALT, and SHALL decode mem_cmd, mem_addr and mem_wdata combinationally from the state and latched registers.
REQ-026 FETCH SHALL drive mem_cmd=READ and mem_addr=pc, and SHALL hold until mem_ready; on mem_ready it SHALL load ir<=mem_rdata, set pc<=pc+1 (modulo 2^ADDR_W, so all-ones wraps to 0), set ir_valid<=1 and go to EXEC.
REQ-027 EXEC SHALL drive mem_cmd=NONE and SHALL apply the priority halt > ld_req > st_req > next_req; when ld_req and st_req are asserted together, the load SHALL be taken and the store ignored.
REQ-028 On ld_req or st_req in EXEC, the block SHALL latch dat_addr, st_data and the access direction, then go to DATA.
REQ-029 DATA SHALL drive READ or WRITE at the latched address with mem_wdata=latched st_data; on mem_ready it SHALL pulse dat_done for one cycle, load ld_data<=mem_rdata for loads only, and return to EXEC.
REQ-030 In EXEC with next_req, the block SHALL set pc<=br_take ? br_target : pc, clear ir_valid and go to FETCH.
REQ-031 The halt input SHALL be honoured only in EXEC; HALT SHALL drive mem_cmd=NONE, keep ir_valid=0, and be left only by reset.
REQ-032 With mem_ready tied to 1, instruction latency from entering FETCH to ir_valid SHALL be exactly one cycle, and a data access SHALL complete one cycle after its request.
REQ-033 Requests arriving outside EXEC SHALL be ignored without being queued.

Reset
REQ-034 Asserting reset SHALL immediately force state=FETCH, pc=RESET_PC, ir=0, ir_valid=0, ld_data=0, dat_done=0, err=0 and the wait counter to 0, including mid-access.
REQ-035 The first READ SHALL appear in the first cycle after reset is released.

Configuration
REQ-036 With FMU_TIMEOUT_EN defined, a wait counter SHALL count consecutive FETCH/DATA cycles without mem_ready; at TIMEOUT_CYC it SHALL set err=1 and enter HALT.
REQ-037 The wait counter SHALL clear on mem_ready and on every state change.
REQ-038 Without FMU_TIMEOUT_EN, waits SHALL be unbounded and err SHALL be tied to 0.

Verification
REQ-039 Scenario reset: release reset with RESET_PC=5 and mem_ready=1 -> mem_cmd=01 and mem_addr=5; next cycle ir=mem_rdata, ir_valid=1, pc=6.
REQ-040 Scenario branch: next_req=1, br_take=1, br_target=0x1F0 -> next FETCH has mem_addr=0x1F0; without br_take, fetch address = pc.
REQ-041 Scenario wrap: pc=0x1FF with ADDR_W=9, fetch completes -> pc=0x000.
REQ-042 Scenario wait states: ld_req with dat_addr=0x20, mem_ready low for 3 cycles then high with rdata 0xBEEF -> mem_cmd=01 held 4 cycles, ld_data=0xBEEF, dat_done high for 1 cycle.
REQ-043 Scenario collision: ld_req=1 and st_req=1 in the same cycle -> only a READ is issued and no WRITE occurs.
REQ-044 Scenario timeout (FMU_TIMEOUT_EN): mem_ready=0 for 15 cycles in FETCH -> err=1, HALT, mem_cmd=00; assert reset -> err=0 and fetch resumes at RESET_PC.
